// File: rtl/vram_console_ctrl.sv
// vram_console_ctrl: text-console sequencer driving the character VRAM write port.
// Owns the cursor, translates printable/newline/backspace codes and runs screen/line clears.
`default_nettype none

module vram_console_ctrl #(
   parameter int         COLS   = 80,
   parameter int         ROWS   = 60,
   parameter logic [6:0] FILL   = 7'h20,
   parameter int         ADDR_W = 13
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              clear_req,
   input  logic              char_valid,
   input  logic [6:0]        char_data,
   output logic              char_ready,
   output logic              vram_we,
   output logic [ADDR_W-1:0] vram_addr,
   output logic [6:0]        vram_din,
   output logic [ADDR_W-1:0] cursor_addr,
   output logic              busy
);

   localparam int RW    = $clog2(ROWS);
   localparam int CLW   = $clog2(COLS);
   localparam int CW    = ADDR_W + 1;
   localparam int TOTAL = ROWS * COLS;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CLR_ALL  = 2'd1,
      CLR_LINE = 2'd2
   } state_t;

   state_t            state;
   logic [RW-1:0]     row;
   logic [CLW-1:0]    col;
   logic [ADDR_W-1:0] row_base;
   logic [CW-1:0]     clr_cnt;

   logic              accept;
   logic              printable;
   logic              is_newline;
   logic              is_bs;
   logic              last_col;
   logic              last_row;
   logic              row_change;
   logic [RW-1:0]     next_row;
   logic [ADDR_W-1:0] next_base;

   assign char_ready = (state == IDLE) && !clear_req;
   assign busy       = (state != IDLE);

   always_comb begin
      accept     = char_valid && char_ready;
      printable  = (char_data >= 7'h20) && (char_data <= 7'h7E);
      is_newline = (char_data == 7'h0A) || (char_data == 7'h0D);
      is_bs      = (char_data == 7'h08);
      last_col   = (col == CLW'(COLS - 1));
      last_row   = (row == RW'(ROWS - 1));
      // Wrapping to row 0 is not a scroll: the new row is simply cleared in place.
      next_row   = last_row ? '0 : row + RW'(1);
      next_base  = last_row ? '0 : row_base + ADDR_W'(COLS);
      row_change = accept && (is_newline || (printable && last_col));
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state       <= CLR_ALL;
         row         <= '0;
         col         <= '0;
         row_base    <= '0;
         cursor_addr <= '0;
         clr_cnt     <= '0;
         vram_we     <= 1'b0;
         vram_addr   <= '0;
         vram_din    <= '0;
      end else begin
         vram_we <= 1'b0;
         case (state)
            IDLE: begin
               if (clear_req) begin
                  state   <= CLR_ALL;
                  clr_cnt <= '0;
               end else if (accept) begin
                  if (printable) begin
                     vram_we   <= 1'b1;
                     vram_addr <= cursor_addr;
                     vram_din  <= char_data;
                     if (!last_col) begin
                        col         <= col + CLW'(1);
                        cursor_addr <= cursor_addr + ADDR_W'(1);
                     end
                  end else if (is_bs && (col != '0)) begin
                     col         <= col - CLW'(1);
                     cursor_addr <= cursor_addr - ADDR_W'(1);
                     vram_we     <= 1'b1;
                     vram_addr   <= cursor_addr - ADDR_W'(1);
                     vram_din    <= FILL;
                  end
                  if (row_change) begin
                     col         <= '0;
                     row         <= next_row;
                     row_base    <= next_base;
                     cursor_addr <= next_base;
                     clr_cnt     <= '0;
                     state       <= CLR_LINE;
                  end
               end
            end
            CLR_ALL: begin
               if (clr_cnt == CW'(TOTAL)) begin
                  state       <= IDLE;
                  row         <= '0;
                  col         <= '0;
                  row_base    <= '0;
                  cursor_addr <= '0;
               end else begin
                  vram_we   <= 1'b1;
                  vram_addr <= ADDR_W'(clr_cnt);
                  vram_din  <= FILL;
                  clr_cnt   <= clr_cnt + CW'(1);
               end
            end
            CLR_LINE: begin
               if (clr_cnt == CW'(COLS)) begin
                  state <= IDLE;
               end else begin
                  vram_we   <= 1'b1;
                  vram_addr <= row_base + ADDR_W'(clr_cnt);
                  vram_din  <= FILL;
                  clr_cnt   <= clr_cnt + CW'(1);
               end
            end
            default: begin
               state   <= CLR_ALL;
               clr_cnt <= '0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_vram_console_ctrl.sv
// tb_vram_console_ctrl: randomized scoreboard bench for vram_console_ctrl.
// A screen-level model predicts VRAM writes; a monitor pops and compares each observed write.
`default_nettype none

module tb_vram_console_ctrl;

   localparam int COLS   = 80;
   localparam int ROWS   = 60;
   localparam int FILL   = 'h20;
   localparam int ADDR_W = 13;

   logic              clk;
   logic              clrn;
   logic              clear_req;
   logic              char_valid;
   logic [6:0]        char_data;
   logic              char_ready;
   logic              vram_we;
   logic [ADDR_W-1:0] vram_addr;
   logic [6:0]        vram_din;
   logic [ADDR_W-1:0] cursor_addr;
   logic              busy;

   vram_console_ctrl #(
      .COLS(COLS), .ROWS(ROWS), .FILL(7'h20), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .clrn(clrn), .clear_req(clear_req),
      .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
      .vram_we(vram_we), .vram_addr(vram_addr), .vram_din(vram_din),
      .cursor_addr(cursor_addr), .busy(busy)
   );

   typedef struct {
      int addr;
      int data;
      bit clr;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   m_row  = 0;
   int   m_col  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s t=%0t", name, $time);
   endtask

   // Screen-level reference model: cells are row*COLS+col, writes queued in issue order.
   task automatic push_w(input int a, input int d, input bit c);
      exp_t e;
      e.addr = a; e.data = d; e.clr = c;
      q.push_back(e);
   endtask

   task automatic push_full_clear();
      for (int i = 0; i < ROWS * COLS; i++) push_w(i, FILL, 1'b1);
   endtask

   task automatic model_newrow();
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
      for (int i = 0; i < COLS; i++) push_w(m_row * COLS + i, FILL, 1'b1);
   endtask

   task automatic model_char(input int c);
      if (c >= 'h20 && c <= 'h7E) begin
         push_w(m_row * COLS + m_col, c, 1'b0);
         if (m_col == COLS - 1) model_newrow();
         else m_col++;
      end else if (c == 'h0A || c == 'h0D) begin
         model_newrow();
      end else if (c == 'h08 && m_col > 0) begin
         m_col--;
         push_w(m_row * COLS + m_col, FILL, 1'b0);
      end
   endtask

   // Monitor: every presented write must match the head of the expectation queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (clrn && vram_we) begin
            if (q.size() == 0) begin
               fail($sformatf("unexpected_write addr=%0d data=%0d", vram_addr, vram_din));
            end else begin
               e = q.pop_front();
               chk("write_addr", int'(vram_addr), e.addr);
               chk("write_data", int'(vram_din), e.data);
               if (e.clr) chk("ready_during_clear", int'(char_ready), 0);
            end
         end
      end
   end

   // All driver tasks start and end at negedge+1.
   task automatic send(input int c);
      bit done;
      done       = 1'b0;
      char_data  = 7'(c);
      char_valid = 1'b1;
      for (int t = 0; t < 6000 && !done; t++) begin
         if (char_ready) done = 1'b1;
         else begin
            @(negedge clk); #1;
         end
      end
      if (!done) begin
         char_valid = 1'b0;
         fail("send_timeout");
      end else begin
         model_char(c);
         @(negedge clk); #1;
         char_valid = 1'b0;
         chk("cursor_after_char", int'(cursor_addr), m_row * COLS + m_col);
      end
   endtask

   task automatic wait_drain_ready();
      bit done;
      done = 1'b0;
      for (int t = 0; t < 10000 && !done; t++) begin
         if (q.size() == 0) done = 1'b1;
         else begin
            @(negedge clk); #1;
         end
      end
      if (!done) fail("drain_timeout");
      else begin
         @(negedge clk); #1;
         chk("ready_after_last_clear_write", int'(char_ready), 1);
      end
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int t = 0; t < 10000 && !done; t++) begin
         if (!busy && q.size() == 0) done = 1'b1;
         else begin
            @(negedge clk); #1;
         end
      end
      if (!done) fail("idle_timeout");
   endtask

   task automatic do_clear_req();
      clear_req  = 1'b1;
      char_valid = 1'b1;
      char_data  = 7'h41;
      #1;
      chk("ready_with_clear_req", int'(char_ready), 0);
      if (!busy) begin
         m_row = 0;
         m_col = 0;
         push_full_clear();
      end
      @(negedge clk); #1;
      clear_req  = 1'b0;
      char_valid = 1'b0;
   endtask

   task automatic check_reset_outputs();
      chk("rst_vram_we", int'(vram_we), 0);
      chk("rst_vram_addr", int'(vram_addr), 0);
      chk("rst_vram_din", int'(vram_din), 0);
      chk("rst_cursor", int'(cursor_addr), 0);
      chk("rst_busy", int'(busy), 1);
      chk("rst_ready", int'(char_ready), 0);
   endtask

   initial begin
      int others [6];
      int r;
      others = '{0, 1, 7, 9, 'h1B, 'h7F};
      clrn       = 1'b0;
      clear_req  = 1'b0;
      char_valid = 1'b0;
      char_data  = 7'h00;

      // Power-up clear
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs();
      push_full_clear();
      clrn = 1'b1;
      wait_drain_ready();
      wait_idle();
      chk("cursor_after_powerup", int'(cursor_addr), 0);

      // First printable, throughput preserved
      send('h41);
      chk("ready_after_print", int'(char_ready), 1);
      for (int i = 0; i < 4; i++) send($urandom_range('h20, 'h7E));
      chk("cursor_col5", int'(cursor_addr), 5);

      // Newline clears the next row
      send('h0A);
      wait_drain_ready();
      chk("cursor_after_newline", int'(cursor_addr), 80);

      // Walk to the last row, then wrap by filling it
      for (int i = 0; i < ROWS - 2; i++) send(($urandom_range(0, 1) != 0) ? 'h0A : 'h0D);
      wait_idle();
      chk("cursor_row59", int'(cursor_addr), (ROWS - 1) * COLS);
      for (int i = 0; i < COLS; i++) send($urandom_range('h20, 'h7E));
      wait_drain_ready();
      chk("cursor_after_wrap", int'(cursor_addr), 0);

      // Backspace, including at column 0
      for (int i = 0; i < 3; i++) send($urandom_range('h20, 'h7E));
      send('h08);
      chk("cursor_after_bs", int'(cursor_addr), 2);
      for (int i = 0; i < 3; i++) send('h08);
      wait_idle();
      chk("cursor_bs_col0", int'(cursor_addr), 0);

      // clear_req beats a simultaneous char; reset mid-clear restarts from 0
      for (int i = 0; i < 7; i++) send($urandom_range('h20, 'h7E));
      do_clear_req();
      repeat (200) @(negedge clk);
      #1;
      clrn = 1'b0;
      #1;
      check_reset_outputs();
      q.delete();
      m_row = 0;
      m_col = 0;
      push_full_clear();
      repeat (2) @(negedge clk);
      #1;
      clrn = 1'b1;
      wait_drain_ready();
      wait_idle();
      chk("cursor_after_reclear", int'(cursor_addr), 0);

      // Randomized traffic
      for (int n = 0; n < 250; n++) begin
         r = $urandom_range(0, 199);
         if (r < 140)      send($urandom_range('h20, 'h7E));
         else if (r < 156) send('h0A);
         else if (r < 164) send('h0D);
         else if (r < 184) send('h08);
         else if (r < 198) send(others[$urandom_range(0, 5)]);
         else begin
            wait_idle();
            do_clear_req();
            wait_drain_ready();
         end
      end
      wait_idle();
      chk("cursor_final", int'(cursor_addr), m_row * COLS + m_col);
      chk("queue_empty", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #950000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
